// File: rtl/message_sequencer_pkg.sv
// Shared constants for UART message blocks: default message geometry and the
// sequencer FSM encoding.
package message_sequencer_pkg;

  localparam int MSG_LEN_DEFAULT = 16;
  localparam int ADDR_W_DEFAULT  = 4;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_SEND   = 2'd2;
  localparam logic [1:0] ST_FINISH = 2'd3;

endpackage

// File: rtl/message_sequencer_if.sv
// Bus between the message sequencer and its peers: the message ROM (addr/data)
// and the UART transmitter (byte/strobe/busy).
interface message_sequencer_if
  import message_sequencer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic [ADDR_W-1:0] msg_addr;
  logic [7:0]        msg_data;
  logic              tx_busy;
  logic [7:0]        tx_data;
  logic              tx_new_data;

  modport master (
    output msg_addr, tx_data, tx_new_data,
    input  msg_data, tx_busy
  );

  modport slave (
    input  msg_addr, tx_data, tx_new_data,
    output msg_data, tx_busy
  );

endinterface

// File: rtl/message_sequencer.sv
// Streams a fixed-length message from an external ROM into a UART transmitter,
// one byte per SEND, optionally repeating; abort or reset drops back to IDLE.
module message_sequencer
  import message_sequencer_pkg::*;
#(
  parameter int MSG_LEN = MSG_LEN_DEFAULT,
  parameter int ADDR_W  = ADDR_W_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic repeat_en,
  input  logic abort,
  output logic busy,
  output logic done,
  message_sequencer_if.master bus
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MSG_LEN - 1);

  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic              strobe_nx, done_nx;
  logic [7:0]        tx_data_q;
  logic              tx_new_data_q, busy_q, done_q;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned and infers a latch.
    state_nx  = state;
    addr_nx   = addr;
    strobe_nx = 1'b0;
    done_nx   = 1'b0;

    unique case (state)
      ST_IDLE: begin
        if (start) begin
          addr_nx  = '0;
          state_nx = ST_FETCH;
        end
      end
      // Guard cycle: covers ROM latency and lets the UART raise tx_busy
      // after the previous strobe before the next SEND decision.
      ST_FETCH: state_nx = ST_SEND;
      ST_SEND: begin
        if (!bus.tx_busy) begin
          strobe_nx = 1'b1;
          if (addr == LAST_ADDR) begin
            state_nx = ST_FINISH;
          end else begin
            addr_nx  = addr + ADDR_W'(1);
            state_nx = ST_FETCH;
          end
        end
      end
      ST_FINISH: begin
        if (repeat_en) begin
          addr_nx  = '0;
          state_nx = ST_FETCH;
        end else begin
          done_nx  = 1'b1;
          state_nx = ST_IDLE;
        end
      end
      default: begin
        addr_nx  = '0;
        state_nx = ST_IDLE;
      end
    endcase

    // Abort overrides every state, including a start in IDLE.
    if (abort) begin
      state_nx  = ST_IDLE;
      addr_nx   = '0;
      strobe_nx = 1'b0;
      done_nx   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= ST_IDLE;
      addr          <= '0;
      tx_data_q     <= 8'h00;
      tx_new_data_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state         <= state_nx;
      addr          <= addr_nx;
      tx_new_data_q <= strobe_nx;
      busy_q        <= (state_nx != ST_IDLE);
      done_q        <= done_nx;
      if (strobe_nx) tx_data_q <= bus.msg_data;
    end
  end

  assign bus.msg_addr    = addr;
  assign bus.tx_data     = tx_data_q;
  assign bus.tx_new_data = tx_new_data_q;
  assign busy            = busy_q;
  assign done            = done_q;

endmodule

// File: tb/tb_message_sequencer.sv
// Directed bench for message_sequencer: ROM and UART models, a byte scoreboard
// filled when a pass is launched and drained on every tx_new_data strobe.
module tb_message_sequencer;
  import message_sequencer_pkg::*;

  localparam int MSG_LEN = 16;
  localparam int ADDR_W  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, repeat_en = 1'b0, abort = 1'b0;
  logic busy, done;

  message_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  message_sequencer #(.MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .repeat_en(repeat_en),
    .abort(abort), .busy(busy), .done(done), .bus(bus)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0, strobes = 0, dones = 0;
  int last_strobe_cyc = 0, first_strobe_cyc = 0;
  bit have_last = 1'b0;
  int busy_len = 0, busy_cnt = 0;
  logic [7:0] rom [MSG_LEN];
  logic [7:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ROM with one-cycle read latency
  always @(posedge clk) bus.msg_data <= rom[bus.msg_addr];

  // UART model: stays busy for busy_len cycles after each accepted byte
  always @(posedge clk) begin
    if (bus.tx_new_data && busy_len > 0) busy_cnt <= busy_len;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign bus.tx_busy = (busy_cnt != 0);

  always @(posedge clk) cyc++;

  // Output monitor: strobes drain the scoreboard, done is timed against the last strobe
  always @(negedge clk) begin
    if (bus.tx_new_data) begin
      check("strobe_while_tx_busy", bus.tx_busy, 1'b0);
      check("sb_has_entry", sb.size() > 0, 1'b1);
      if (sb.size() > 0) check("tx_data", bus.tx_data, sb.pop_front());
      if (have_last) check("strobe_gap_ge2", (cyc - last_strobe_cyc) >= 2, 1'b1);
      else first_strobe_cyc = cyc;
      last_strobe_cyc = cyc;
      have_last = 1'b1;
      strobes++;
    end
    if (done) begin
      check("done_after_last_strobe", cyc, last_strobe_cyc + 1);
      dones++;
    end
  end

  task automatic push_msg(input int n);
    for (int i = 0; i < n; i++) sb.push_back(rom[i]);
  endtask

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic wait_strobes(input int target, input int budget);
    int n = 0;
    while (strobes < target && n < budget) begin
      step();
      n++;
    end
    check("wait_strobes_in_budget", strobes >= target, 1'b1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (dones < target && n < budget) begin
      step();
      n++;
    end
    check("wait_done_in_budget", dones >= target, 1'b1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_msg_addr"}, bus.msg_addr, '0);
    check({tag, "_tx_data"}, bus.tx_data, 8'h00);
    check({tag, "_tx_new_data"}, bus.tx_new_data, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    string msg;
    int s0, d0;
    msg = "Hello \n\rWorld!\n\r";
    for (int i = 0; i < MSG_LEN; i++) rom[i] = msg[i];

    // Reset values
    #3;
    check_reset_outputs("por");
    step();
    rst = 1'b1;
    step();
    check("idle_busy", busy, 1'b0);

    // Single pass, UART always ready
    s0 = strobes; d0 = dones; have_last = 1'b0;
    push_msg(MSG_LEN);
    pulse_start();
    check("busy_after_start", busy, 1'b1);
    wait_done(d0 + 1, 200);
    check("p1_strobes", strobes - s0, MSG_LEN);
    check("p1_span", last_strobe_cyc - first_strobe_cyc, 2 * (MSG_LEN - 1));
    check("p1_last_byte", bus.tx_data, 8'h0D);
    check("p1_busy_with_done", busy, 1'b0);
    step();
    check("p1_done_one_cycle", done, 1'b0);
    check("p1_sb_empty", sb.size(), 0);

    // UART busy 10 cycles per byte
    busy_len = 10;
    s0 = strobes; d0 = dones; have_last = 1'b0;
    push_msg(MSG_LEN);
    pulse_start();
    wait_done(d0 + 1, 1000);
    check("slow_strobes", strobes - s0, MSG_LEN);
    check("slow_sb_empty", sb.size(), 0);
    busy_len = 0;
    repeat (12) step();

    // Two passes with repeat_en
    s0 = strobes; d0 = dones; have_last = 1'b0;
    repeat_en = 1'b1;
    push_msg(MSG_LEN);
    push_msg(MSG_LEN);
    pulse_start();
    wait_strobes(s0 + MSG_LEN + 1, 200);
    check("rep_no_done_pass1", dones - d0, 0);
    repeat_en = 1'b0;
    wait_done(d0 + 1, 200);
    check("rep_strobes", strobes - s0, 2 * MSG_LEN);
    check("rep_dones", dones - d0, 1);
    check("rep_sb_empty", sb.size(), 0);

    // Abort after 5th strobe, then restart from address 0
    s0 = strobes; d0 = dones; have_last = 1'b0;
    push_msg(5);
    pulse_start();
    wait_strobes(s0 + 5, 100);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", busy, 1'b0);
    check("abort_addr", bus.msg_addr, '0);
    repeat (30) step();
    check("abort_strobes", strobes - s0, 5);
    check("abort_no_done", dones - d0, 0);
    s0 = strobes; have_last = 1'b0;
    push_msg(MSG_LEN);
    pulse_start();
    wait_done(d0 + 1, 200);
    check("resume_strobes", strobes - s0, MSG_LEN);

    // start during a pass is ignored
    s0 = strobes; d0 = dones; have_last = 1'b0;
    push_msg(MSG_LEN);
    pulse_start();
    wait_strobes(s0 + 7, 100);
    pulse_start();
    wait_done(d0 + 1, 200);
    repeat (40) step();
    check("ignored_start_strobes", strobes - s0, MSG_LEN);
    check("ignored_start_busy", busy, 1'b0);

    // start and abort together in IDLE
    s0 = strobes;
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start_abort_busy", busy, 1'b0);
    repeat (10) step();
    check("start_abort_strobes", strobes - s0, 0);

    // Reset mid-message
    s0 = strobes; have_last = 1'b0;
    push_msg(MSG_LEN);
    pulse_start();
    wait_strobes(s0 + 3, 100);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    sb.delete();
    repeat (3) step();
    rst = 1'b1;
    repeat (30) step();
    check("post_rst_strobes", strobes - s0, 3);
    check("post_rst_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
